// File: rtl/diff_check_pkg.sv
// Shared definitions for the output difference checker.
//   state_t         checker FSM states
//   DEFAULT_POLY    default MISR feedback polynomial
//   chunk_count()   number of SIG_W-bit chunks needed to cover a WIDTH-bit word
package diff_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;

    function automatic int chunk_count(input int width, input int sig_w);
        return (width + sig_w - 1) / sig_w;
    endfunction

endpackage

// File: rtl/misr_fold.sv
// Folds a wide word into SIG_W bits (XOR of consecutive SIG_W-bit chunks,
// last chunk zero-extended) and compacts the folded stream into a MISR.
//   clk   in   clock
//   rst   in   synchronous active-high reset, clears the signature
//   clr   in   synchronous clear at the start of a window
//   en    in   fold data into the signature this cycle
//   data  in   WIDTH-bit word
//   sig   out  current signature
module misr_fold
    import diff_check_pkg::*;
#(
    parameter int          WIDTH = 246,
    parameter int          SIG_W = 32,
    parameter logic [SIG_W-1:0] POLY = SIG_W'(DEFAULT_POLY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] data,
    output logic [SIG_W-1:0] sig
);

    localparam int NCH = chunk_count(WIDTH, SIG_W);

    logic [NCH*SIG_W-1:0] padded;
    logic [SIG_W-1:0]     fold;
    logic [SIG_W-1:0]     sig_next;

    always_comb begin
        padded              = '0;
        padded[WIDTH-1:0]   = data;
        fold                = '0;
        for (int i = 0; i < NCH; i++) begin
            fold = fold ^ padded[i*SIG_W +: SIG_W];
        end
        sig_next = (sig << 1) ^ (sig[SIG_W-1] ? POLY : '0) ^ fold;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/output_diff_checker.sv
// Compares reference and netlist output words sample by sample over a fixed
// window, keeps a sticky mismatch flag, first failing index, saturating fail
// count, and a MISR signature per stream.
//   clk, rst            clock, synchronous active-high reset
//   start               begins a window (IDLE or DONE only)
//   sample_en           y_ref/y_dut valid this cycle
//   y_ref, y_dut        words under comparison
//   busy, done          RUN / DONE status
//   mismatch            sticky difference flag for the current window
//   first_fail          index of first differing sample, all-ones if none
//   fail_count          saturating count of differing samples
//   sig_ref, sig_dut    stream signatures
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | accepting samples until NUM_SAMPLES have been taken
// DONE  | window complete, results held until start or rst
module output_diff_checker
    import diff_check_pkg::*;
#(
    parameter int               WIDTH       = 246,
    parameter int               SIG_W       = 32,
    parameter logic [SIG_W-1:0] POLY        = SIG_W'(DEFAULT_POLY),
    parameter int               NUM_SAMPLES = 21,
    parameter int               CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] y_ref,
    input  logic [WIDTH-1:0] y_dut,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [CNT_W-1:0] first_fail,
    output logic [CNT_W-1:0] fail_count,
    output logic [SIG_W-1:0] sig_ref,
    output logic [SIG_W-1:0] sig_dut
);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             clr;
    logic             accept;
    logic             last;
    logic             differ;

    assign clr    = start && (state != RUN);
    assign accept = (state == RUN) && sample_en;
    assign last   = (cnt == CNT_W'(NUM_SAMPLES - 1));
    assign differ = (y_ref != y_dut);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (accept && last) state_next = DONE;
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt        <= '0;
            mismatch   <= 1'b0;
            first_fail <= '1;
            fail_count <= '0;
        end else if (accept) begin
            cnt <= cnt + 1'b1;
            if (differ) begin
                mismatch <= 1'b1;
                if (fail_count != '1) begin
                    fail_count <= fail_count + 1'b1;
                end
                // Only the first difference in the window records its index.
                if (!mismatch) begin
                    first_fail <= cnt;
                end
            end
        end
    end

    misr_fold #(.WIDTH(WIDTH), .SIG_W(SIG_W), .POLY(POLY)) u_misr_ref (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .en   (accept),
        .data (y_ref),
        .sig  (sig_ref)
    );

    misr_fold #(.WIDTH(WIDTH), .SIG_W(SIG_W), .POLY(POLY)) u_misr_dut (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .en   (accept),
        .data (y_dut),
        .sig  (sig_dut)
    );

endmodule

// File: tb/tb_output_diff_checker.sv
module tb_output_diff_checker;

    localparam int          W    = 246;
    localparam int          N    = 21;
    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic         clk = 1'b0;
    logic         rst, start, sample_en, start1, en1;
    logic [W-1:0] y_ref, y_dut;

    logic         busy, done, mismatch;
    logic [7:0]   first_fail, fail_count;
    logic [31:0]  sig_ref, sig_dut;

    logic         busy1, done1, mismatch1;
    logic [7:0]   first_fail1, fail_count1;
    logic [31:0]  sig_ref1, sig_dut1;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    output_diff_checker #(.WIDTH(W), .SIG_W(32), .POLY(POLY), .NUM_SAMPLES(N), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .sample_en(sample_en),
        .y_ref(y_ref), .y_dut(y_dut),
        .busy(busy), .done(done), .mismatch(mismatch),
        .first_fail(first_fail), .fail_count(fail_count),
        .sig_ref(sig_ref), .sig_dut(sig_dut)
    );

    output_diff_checker #(.WIDTH(W), .SIG_W(32), .POLY(POLY), .NUM_SAMPLES(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sample_en(en1),
        .y_ref(y_ref), .y_dut(y_dut),
        .busy(busy1), .done(done1), .mismatch(mismatch1),
        .first_fail(first_fail1), .fail_count(fail_count1),
        .sig_ref(sig_ref1), .sig_dut(sig_dut1)
    );

    // ---------------- behavioural reference model ----------------
    // phase: 0 idle, 1 running, 2 finished
    int          m_phase;
    int          m_taken;
    bit          m_mm;
    int          m_first;
    int          m_fails;
    logic [31:0] m_sref, m_sdut;
    bit          model_live = 0;

    function automatic logic [31:0] mfold(input logic [W-1:0] w);
        logic [31:0] f = '0;
        for (int b = 0; b < W; b++) f[b % 32] = f[b % 32] ^ w[b];
        return f;
    endfunction

    function automatic logic [31:0] mmisr(input logic [31:0] s, input logic [W-1:0] w);
        logic [31:0] n = {s[30:0], 1'b0};
        if (s[31]) n = n ^ POLY;
        return n ^ mfold(w);
    endfunction

    task automatic model_clear();
        m_taken = 0; m_mm = 0; m_first = 255; m_fails = 0;
        m_sref = '0; m_sdut = '0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            model_clear();
            model_live = 1;
        end else if (m_phase != 1) begin
            if (start) begin
                model_clear();
                m_phase = 1;
            end
        end else if (sample_en) begin
            m_sref = mmisr(m_sref, y_ref);
            m_sdut = mmisr(m_sdut, y_dut);
            if (y_ref != y_dut) begin
                if (!m_mm) m_first = m_taken;
                m_mm = 1;
                if (m_fails < 255) m_fails++;
            end
            m_taken++;
            if (m_taken == N) m_phase = 2;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_live) begin
            chk("busy",       32'(busy),       32'(m_phase == 1));
            chk("done",       32'(done),       32'(m_phase == 2));
            chk("mismatch",   32'(mismatch),   32'(m_mm));
            chk("first_fail", 32'(first_fail), 32'(m_first));
            chk("fail_count", 32'(fail_count), 32'(m_fails));
            chk("sig_ref",    sig_ref,         m_sref);
            chk("sig_dut",    sig_dut,         m_sdut);
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [W-1:0] rword();
        logic [255:0] t;
        for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
        return t[W-1:0];
    endfunction

    task automatic step(input logic r, input logic s, input logic e,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        rst = r; start = s; sample_en = e; y_ref = a; y_dut = b;
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] a, b, flip, ones;
    int           idx;

    initial begin
        rst = 1; start = 0; sample_en = 0; start1 = 0; en1 = 0;
        y_ref = '0; y_dut = '0;
        flip = '0; flip[W-1] = 1'b1;
        ones = '1;

        // reset with random inputs
        for (int i = 0; i < 2; i++) step(1, 1'($urandom), 1'($urandom), rword(), rword());
        chk("rst_busy", 32'(busy), 0);
        chk("rst_first_fail", 32'(first_fail), 32'hFF);
        chk("rst_sig_dut", sig_dut, 0);

        // all-zero match window
        step(0, 1, 0, '0, '0);
        for (int i = 0; i < N; i++) begin
            step(0, 0, 1, '0, '0);
            if (i == N - 2) chk("zero_not_done_early", 32'(done), 0);
        end
        chk("zero_done", 32'(done), 1);
        chk("zero_first_fail", 32'(first_fail), 32'hFF);
        chk("zero_sig_ref", sig_ref, 0);

        // single MSB difference on sample 3
        step(0, 1, 0, '0, '0);
        for (int i = 0; i < N; i++) begin
            a = rword();
            step(0, 0, 1, a, (i == 3) ? (a ^ flip) : a);
        end
        chk("single_first_fail", 32'(first_fail), 3);
        chk("single_fail_count", 32'(fail_count), 1);
        vectors++;
        if (sig_ref === sig_dut) begin
            errors++;
            $display("FAIL single_sig_differ: sig_ref %0h sig_dut %0h must differ", sig_ref, sig_dut);
        end

        // failures at 5, 6, 20 with a 4-cycle stall
        step(0, 1, 0, '0, '0);
        idx = 0;
        while (idx < N) begin
            if (idx == 10) begin
                for (int s = 0; s < 4; s++) step(0, 0, 0, rword(), rword());
            end
            a = rword();
            b = (idx == 5 || idx == 6 || idx == 20) ? (a ^ (rword() | W'(1))) : a;
            step(0, 0, 1, a, b);
            idx++;
            if (idx == N - 1) chk("multi_not_done_20", 32'(done), 0);
        end
        chk("multi_done", 32'(done), 1);
        chk("multi_first_fail", 32'(first_fail), 5);
        chk("multi_fail_count", 32'(fail_count), 3);

        // start ignored in RUN, then rst after 10 samples, then clean window
        step(0, 1, 0, '0, '0);
        for (int i = 0; i < 10; i++) begin
            a = rword();
            step(0, (i == 4), 1, a, (i == 2) ? ~a : a);
        end
        chk("midrun_mismatch", 32'(mismatch), 1);
        step(1, 0, 1, rword(), rword());
        chk("midrun_rst_busy", 32'(busy), 0);
        chk("midrun_rst_done", 32'(done), 0);
        chk("midrun_rst_fail_count", 32'(fail_count), 0);
        step(0, 1, 0, '0, '0);
        for (int i = 0; i < N; i++) begin
            a = rword();
            step(0, 0, 1, a, a);
        end
        chk("clean_done", 32'(done), 1);
        chk("clean_mismatch", 32'(mismatch), 0);

        // golden signature on a single-sample window
        start1 = 1;
        step(0, 0, 0, '0, '0);
        start1 = 0;
        chk("gold_busy", 32'(busy1), 1);
        en1 = 1;
        step(0, 0, 0, ones, ones);
        en1 = 0;
        chk("gold_done", 32'(done1), 1);
        chk("gold_sig_ref", sig_ref1, 32'hFFC00000);
        chk("gold_sig_dut", sig_dut1, 32'hFFC00000);
        chk("gold_mismatch", 32'(mismatch1), 0);
        chk("model_gold", mmisr(32'h0, ones), 32'hFFC00000);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            a = rword();
            b = ($urandom_range(0, 3) == 0) ? (a ^ (W'(1) << $urandom_range(0, W - 1))) : a;
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) != 0), a, b);
        end

        step(0, 0, 0, '0, '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
